// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for the bit-serial adder.
//   start        : request, accepted when the adder is not busy
//   a, b, cin    : operands and carry-in, captured on the accepting edge
//   sum, cout    : registered result, updated only on the completion edge
//   busy         : high while bits are being processed
//   done         : one-cycle pulse after sum/cout were written
// master drives the request side, slave is the adder itself.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin,
    input  sum, cout, busy, done
  );

  modport slave (
    input  start, a, b, cin,
    output sum, cout, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop,
// one result bit per clock, WIDTH-cycle latency, issue interval WIDTH+1.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active low
//   bus   : serial_adder_if slave (start/a/b/cin in, sum/cout/busy/done out)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  // One extra bit so a power-of-two WIDTH never wraps the counter.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             load;
  logic             last;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] ps_nx;
  logic             carry;
  logic             carry_nx;
  logic             s;
  logic [CW-1:0]    cnt;

  // State register; busy/done are registered from the next state so
  // they are plain flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.busy <= (state_nx == RUN);
      bus.done <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Full-adder slice on the current LSBs.
  assign s        = sa[0] ^ sb[0] ^ carry;
  assign carry_nx = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));

  // Result bits enter at the MSB so bit 0 lands in the LSB after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_ps_w1
      assign ps_nx = s;
    end else begin : g_ps_wn
      assign ps_nx = {s, ps[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      ps       <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else if (load) begin
      sa    <= bus.a;
      sb    <= bus.b;
      carry <= bus.cin;
      ps    <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      carry <= carry_nx;
      ps    <= ps_nx;
      cnt   <= cnt + 1'b1;
      if (last) begin
        // Take the shifter including this cycle's bit, not the stale register.
        bus.sum  <= ps_nx;
        bus.cout <= carry_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  if8();
  serial_adder_if #(.WIDTH(1))  if1();
  serial_adder_if #(.WIDTH(16)) if16();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  int checks = 0;
  int errors = 0;

  // Scoreboards of expected {cout,sum}, pushed when a start is driven.
  logic [8:0]  q8[$];
  logic [1:0]  q1[$];
  logic [16:0] q16[$];

  // Drive a start on the 8-bit DUT for one cycle; returns at the negedge
  // after the accepting edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    if8.a     = a;
    if8.b     = b;
    if8.cin   = cin;
    if8.start = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
    @(negedge clk);
    if8.start = 1'b0;
  endtask

  // Wait (bounded) for done on the 8-bit DUT; lat counts negedges since
  // the accepting edge, nb counts cycles seen busy.
  task automatic wait_done8(output int lat, output int nb);
    lat = 0;
    nb  = 0;
    while (!if8.done && lat < 40) begin
      if (if8.busy) nb++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if8.sum, if8.cout, if8.busy, if8.done} !== 11'h000) begin
      errors++;
      $display("FAIL reset8 got %h exp 000", {if8.sum, if8.cout, if8.busy, if8.done});
    end
    checks++;
    if ({if1.sum, if1.cout, if1.busy, if1.done} !== 4'h0) begin
      errors++;
      $display("FAIL reset1 got %h exp 0", {if1.sum, if1.cout, if1.busy, if1.done});
    end
    checks++;
    if ({if16.sum, if16.cout, if16.busy, if16.done} !== 19'h0) begin
      errors++;
      $display("FAIL reset16 got %h exp 0", {if16.sum, if16.cout, if16.busy, if16.done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({if8.busy, if8.done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got %b exp 00", {if8.busy, if8.done});
    end
  endtask

  task automatic test_basic;
    int lat, nb;
    logic [8:0] exp;
    start8(8'h5A, 8'h33, 1'b0);
    wait_done8(lat, nb);
    exp = q8.pop_front();
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
    checks++;
    if (nb !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", nb); end
    checks++;
    if ({if8.cout, if8.sum} !== exp) begin
      errors++; $display("FAIL basic_sum got %h exp %h", {if8.cout, if8.sum}, exp);
    end
    @(negedge clk);
    checks++;
    if ({if8.done, if8.busy} !== 2'b00) begin
      errors++; $display("FAIL basic_done_pulse got %b exp 00", {if8.done, if8.busy});
    end
    @(negedge clk);
    checks++;
    if ({if8.cout, if8.sum} !== exp) begin
      errors++; $display("FAIL basic_hold got %h exp %h", {if8.cout, if8.sum}, exp);
    end
  endtask

  task automatic test_carry;
    logic [16:0] vec [2];
    int lat, nb;
    logic [8:0] exp;
    vec[0] = {8'hFF, 8'h01, 1'b0};
    vec[1] = {8'hFF, 8'hFF, 1'b1};
    for (int i = 0; i < 2; i++) begin
      start8(vec[i][16:9], vec[i][8:1], vec[i][0]);
      wait_done8(lat, nb);
      exp = q8.pop_front();
      checks++;
      if ({if8.cout, if8.sum} !== exp || lat !== 8) begin
        errors++;
        $display("FAIL carry%0d got %h lat %0d exp %h lat 8", i, {if8.cout, if8.sum}, lat, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int lat, nb;
    logic [8:0] exp;
    if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0; if8.start = 1'b1;
    q8.push_back({1'b0, 8'h12} + {1'b0, 8'h34});
    @(negedge clk);
    // Operands change under a held start while the adder is running.
    if8.a = 8'h00; if8.b = 8'h00;
    wait_done8(lat, nb);
    exp = q8.pop_front();
    checks++;
    if ({if8.cout, if8.sum} !== exp || lat !== 8) begin
      errors++;
      $display("FAIL b2b_first got %h lat %0d exp %h lat 8", {if8.cout, if8.sum}, lat, exp);
    end
    if8.a = 8'h77; if8.b = 8'h11;
    q8.push_back({1'b0, 8'h77} + {1'b0, 8'h11});
    @(negedge clk);
    checks++;
    if ({if8.busy, if8.done} !== 2'b10) begin
      errors++; $display("FAIL b2b_no_idle got %b exp 10", {if8.busy, if8.done});
    end
    if8.start = 1'b0;
    wait_done8(lat, nb);
    exp = q8.pop_front();
    checks++;
    if ({if8.cout, if8.sum} !== exp || lat !== 8) begin
      errors++;
      $display("FAIL b2b_second got %h lat %0d exp %h lat 8", {if8.cout, if8.sum}, lat, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int lat, nb;
    int seen_done;
    logic [8:0] exp;
    start8(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (if8.busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b exp 1", if8.busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if8.sum, if8.cout, if8.busy, if8.done} !== 11'h000) begin
      errors++;
      $display("FAIL midrun_reset got %h exp 000", {if8.sum, if8.cout, if8.busy, if8.done});
    end
    void'(q8.pop_back());
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (if8.done) seen_done++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (if8.done || if8.busy) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++; $display("FAIL midrun_no_done got %0d exp 0", seen_done);
    end
    start8(8'hF0, 8'h0F, 1'b0);
    wait_done8(lat, nb);
    exp = q8.pop_front();
    checks++;
    if ({if8.cout, if8.sum} !== exp || lat !== 8) begin
      errors++;
      $display("FAIL midrun_restart got %h lat %0d exp %h lat 8", {if8.cout, if8.sum}, lat, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep_w1;
    int lat;
    logic [1:0] exp;
    logic a, b, c;
    for (int i = 0; i < 16; i++) begin
      a = i[0]; b = i[1]; c = i[2];
      if (i >= 8) begin a = 1'($urandom); b = 1'($urandom); c = 1'($urandom); end
      if1.a = a; if1.b = b; if1.cin = c; if1.start = 1'b1;
      q1.push_back({1'b0, a} + {1'b0, b} + 2'(c));
      @(negedge clk);
      if1.start = 1'b0;
      lat = 0;
      while (!if1.done && lat < 10) begin @(negedge clk); lat++; end
      exp = q1.pop_front();
      checks++;
      if ({if1.cout, if1.sum} !== exp || lat !== 1) begin
        errors++;
        $display("FAIL w1_op%0d got %b lat %0d exp %b lat 1", i, {if1.cout, if1.sum}, lat, exp);
      end
      repeat (int'($urandom_range(1, 2))) @(negedge clk);
    end
  endtask

  task automatic test_sweep_w16;
    int lat;
    logic [16:0] exp;
    logic [15:0] a, b;
    logic c;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      if (i == 0) begin a = 16'hFFFF; b = 16'hFFFF; c = 1'b1; end
      if (i == 1) begin a = 16'h0000; b = 16'h0000; c = 1'b0; end
      if (i == 2) begin a = 16'hFFFF; b = 16'h0000; c = 1'b1; end
      if16.a = a; if16.b = b; if16.cin = c; if16.start = 1'b1;
      q16.push_back({1'b0, a} + {1'b0, b} + 17'(c));
      @(negedge clk);
      if16.start = 1'b0;
      lat = 0;
      while (!if16.done && lat < 40) begin @(negedge clk); lat++; end
      exp = q16.pop_front();
      checks++;
      if ({if16.cout, if16.sum} !== exp || lat !== 16) begin
        errors++;
        $display("FAIL w16_op%0d got %h lat %0d exp %h lat 16", i, {if16.cout, if16.sum}, lat, exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if8.start  = 1'b0; if8.a  = '0; if8.b  = '0; if8.cin  = 1'b0;
    if1.start  = 1'b0; if1.a  = '0; if1.b  = '0; if1.cin  = 1'b0;
    if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep_w1();
    test_sweep_w16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
